// File: rtl/kernel_mem_test_master.sv
// Memory test master: fills a word range over Avalon-MM with an incrementing
// pattern derived from a seed, then reads it back and counts mismatches.
module kernel_mem_test_master #(
  parameter int ADDR_W = 15,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              verify_only,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [31:0]       seed,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [2:0]        state_dbg
);

  // Bus handshake: a command (chipselect with read or write) is accepted on
  // the first clock edge where waitrequest is low; until then it is held
  // unchanged. Read data arrives exactly one cycle after read acceptance.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    RDWAIT = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]  OFF_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       seed_q, seed_d;
  logic [ADDR_W:0]   offset_q, offset_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_pat;
  logic [ADDR_W:0]   offset_inc;
  logic              last_word;

  always_comb begin
    // Address wraps silently at the top of the address space.
    cur_addr   = base_q + offset_q[ADDR_W-1:0];
    cur_pat    = seed_q + 32'(offset_q);
    offset_inc = offset_q + OFF_ONE;
    last_word  = (offset_inc == count_q);
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    count_d        = count_q;
    seed_d         = seed_q;
    offset_d       = offset_q;
    err_d          = err_q;
    first_d        = first_q;
    avm_address    = '0;
    avm_chipselect = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_byteenable = 4'h0;
    avm_writedata  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          count_d  = word_count;
          seed_d   = seed;
          offset_d = '0;
          err_d    = '0;
          first_d  = '0;
          if (word_count == '0)  state_d = FIN;
          else if (verify_only)  state_d = RD;
          else                   state_d = WR;
        end
      end
      WR: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_byteenable = 4'hF;
        avm_address    = cur_addr;
        avm_writedata  = cur_pat;
        if (!avm_waitrequest) begin
          if (last_word) begin
            offset_d = '0;
            state_d  = RD;
          end else begin
            offset_d = offset_inc;
          end
        end
      end
      RD: begin
        avm_chipselect = 1'b1;
        avm_read       = 1'b1;
        avm_byteenable = 4'hF;
        avm_address    = cur_addr;
        if (!avm_waitrequest) state_d = RDWAIT;
      end
      RDWAIT: begin
        if (avm_readdata != cur_pat) begin
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_ONE;
          // The counter is zero only until the first mismatch of this run.
          if (err_q == '0) first_d = cur_addr;
        end
        if (last_word) begin
          state_d = FIN;
        end else begin
          offset_d = offset_inc;
          state_d  = RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      count_q  <= '0;
      seed_q   <= '0;
      offset_q <= '0;
      err_q    <= '0;
      first_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      seed_q   <= seed_d;
      offset_q <= offset_d;
      err_q    <= err_d;
      first_q  <= first_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FIN);
  assign error_count    = err_q;
  assign first_err_addr = first_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_kernel_mem_test_master.sv
// Bench for kernel_mem_test_master: Avalon memory model with programmable
// wait states, expected-command queue and end-of-run result queue.
module tb_kernel_mem_test_master;
  localparam int ADDR_W = 15;
  localparam int ERR_W  = 16;
  localparam int CW     = 1 + ADDR_W + 32;
  localparam int RW     = ERR_W + ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              verify_only = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   word_count = '0;
  logic [31:0]       seed = '0;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect, avm_read, avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata = '0;
  logic              avm_waitrequest;
  logic              busy, done;
  logic [ERR_W-1:0]  error_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [2:0]        state_dbg;

  kernel_mem_test_master #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .verify_only(verify_only),
    .base_addr(base_addr), .word_count(word_count), .seed(seed),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .error_count(error_count),
    .first_err_addr(first_err_addr), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int done_exp = 0;
  logic [CW-1:0] exp_q[$];
  logic [RW-1:0] res_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  int                wait_n = 0;
  int                wcnt = 0;
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] bad_lo = 15'h0012;
  logic [ADDR_W-1:0] bad_hi = 15'h0013;

  assign avm_waitrequest = avm_chipselect && (wcnt < wait_n);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= 0;
    end else if (avm_chipselect) begin
      if (avm_waitrequest) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        if (avm_write) mem[avm_address] <= avm_writedata;
        if (avm_read)
          avm_readdata <= mem[avm_address] ^
            ((corrupt_en && avm_address >= bad_lo && avm_address <= bad_hi) ? 32'hFFFF_FFFF : 32'h0);
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [CW-1:0] cur_cmd, hold_cmd, exp_cmd;
  logic [RW-1:0] exp_res;
  int            hold_len = 0;
  logic          after_done = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      hold_len   = 0;
      after_done = 1'b0;
    end else begin
      cur_cmd = {avm_write, avm_address, avm_write ? avm_writedata : 32'h0};
      if (after_done) begin
        check("idle_after_done", {62'h0, busy, done}, 64'h0);
        after_done = 1'b0;
      end
      check("strobe_rules", {62'h0, avm_read & avm_write, avm_chipselect ^ (avm_read | avm_write)}, 64'h0);
      if (avm_chipselect) begin
        check("byteenable", 64'(avm_byteenable), 64'hF);
        if (hold_len == 0) hold_cmd = cur_cmd;
        else check("cmd_stable", 64'(cur_cmd), 64'(hold_cmd));
        hold_len++;
        if (!avm_waitrequest) begin
          check("hold_cycles", 64'(hold_len), 64'(wait_n + 1));
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cmd actual=%h required=none", cur_cmd);
          end else begin
            exp_cmd = exp_q.pop_front();
            check("bus_cmd", 64'(cur_cmd), 64'(exp_cmd));
          end
          hold_len = 0;
        end
      end
      if (done) begin
        done_seen++;
        after_done = 1'b1;
        if (res_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_res = res_q.pop_front();
          check("run_result", 64'({error_count, first_err_addr}), 64'(exp_res));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic vonly, input logic [ADDR_W-1:0] base, input int cnt,
                          input logic [31:0] sd, input logic [ERR_W-1:0] e_err,
                          input logic [ADDR_W-1:0] e_first);
    if (!vonly)
      for (int k = 0; k < cnt; k++) exp_q.push_back({1'b1, ADDR_W'(base + k), sd + 32'(k)});
    for (int k = 0; k < cnt; k++) exp_q.push_back({1'b0, ADDR_W'(base + k), 32'h0});
    res_q.push_back({e_err, e_first});
    done_exp++;
  endtask

  task automatic pulse_start(input logic vonly, input logic [ADDR_W-1:0] base, input int cnt,
                             input logic [31:0] sd);
    @(negedge clk);
    verify_only = vonly;
    base_addr   = base;
    word_count  = (ADDR_W+1)'(cnt);
    seed        = sd;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, {63'h0, done}, 64'h1);
  endtask

  task automatic finish_run(input string name, input int budget);
    wait_done(name, budget);
    @(negedge clk);
    @(negedge clk);
    check({name, "_queue_drained"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic run_test(input string name, input logic vonly, input logic [ADDR_W-1:0] base,
                          input int cnt, input logic [31:0] sd, input logic [ERR_W-1:0] e_err,
                          input logic [ADDR_W-1:0] e_first);
    push_exp(vonly, base, cnt, sd, e_err, e_first);
    pulse_start(vonly, base, cnt, sd);
    finish_run(name, 400);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    #3;
    check("reset_bus", 64'({avm_chipselect, avm_read, avm_write, avm_byteenable, avm_address}), 64'h0);
    check("reset_wdata", 64'(avm_writedata), 64'h0);
    check("reset_status", 64'({busy, done, error_count, first_err_addr, state_dbg}), 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_test("fill_verify", 1'b0, 15'h0010, 4, 32'hA5A5_0000, 16'd0, 15'h0);
    run_test("wrap", 1'b0, 15'h7FFE, 4, 32'h1234_5678, 16'd0, 15'h0);

    corrupt_en = 1'b1;
    run_test("corrupt", 1'b1, 15'h0010, 4, 32'hA5A5_0000, 16'd2, 15'h0012);
    corrupt_en = 1'b0;

    wait_n = 3;
    run_test("wait3", 1'b0, 15'h0010, 4, 32'hA5A5_0000, 16'd0, 15'h0);
    wait_n = 0;

    // Zero-length run: no commands are pushed, so any bus activity is flagged.
    push_exp(1'b0, 15'h0040, 0, 32'h0, 16'd0, 15'h0);
    pulse_start(1'b0, 15'h0040, 0, 32'h0);
    wait_done("count0", 2);
    @(negedge clk);
    @(negedge clk);

    // A second start during the run must not disturb the latched parameters.
    push_exp(1'b0, 15'h0020, 3, 32'h0000_0100, 16'd0, 15'h0);
    pulse_start(1'b0, 15'h0020, 3, 32'h0000_0100);
    @(negedge clk);
    verify_only = 1'b1;
    base_addr   = 15'h0100;
    word_count  = 16'd9;
    seed        = 32'hDEAD_BEEF;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    finish_run("start_busy", 400);

    // Abort in the read phase: outputs clear before the next clock edge.
    push_exp(1'b0, 15'h0010, 4, 32'hA5A5_0000, 16'd0, 15'h0);
    pulse_start(1'b0, 15'h0010, 4, 32'hA5A5_0000);
    n = 0;
    while (avm_read !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached_rd", {63'h0, avm_read}, 64'h1);
    #2 reset = 1'b1;
    #1;
    check("abort_bus", 64'({avm_chipselect, avm_read, avm_write, avm_byteenable, avm_address}), 64'h0);
    check("abort_wdata", 64'(avm_writedata), 64'h0);
    check("abort_status", 64'({busy, done, error_count, first_err_addr}), 64'h0);
    exp_q.delete();
    res_q.delete();
    done_exp--;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_test("after_reset", 1'b0, 15'h0010, 4, 32'hA5A5_0000, 16'd0, 15'h0);

    check("done_pulses", 64'(done_seen), 64'(done_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
